// File: rtl/fifo_v3_ft.sv
// Single-clock circular FIFO with optional fall-through bypass and occupancy count.
// Define FIFO_V3_FT_ASSERT_EN to compile in the simulation checks for depth and misuse.
module fifo_v3_ft #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bypass, through, push_eff, pop_eff, write_en;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into an empty fall-through FIFO is presented immediately.
  assign bypass   = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign through  = bypass && pop_i;
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign empty_o  = (cnt_q == '0) && !bypass;
  assign usage_o  = cnt_q;
  assign data_o   = bypass ? data_i : mem_q[rd_ptr_q];
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;
  assign write_en = push_eff && !through && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (!through) begin
      if (push_eff) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_eff)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_eff && !pop_eff) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!push_eff && pop_eff) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset so it can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (write_en) mem_q[wr_ptr_q] <= data_i;
  end

`ifdef FIFO_V3_FT_ASSERT_EN
  if (DEPTH < 1) begin : g_depth_chk
    $fatal(1, "fifo_v3_ft: DEPTH must be >= 1");
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full_o)) else $error("push on full");
      assert (!(pop_i && empty_o)) else $error("pop on empty");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_v3_ft.sv
// Directed scoreboard bench for fifo_v3_ft: three instances cover normal mode,
// fall-through mode and a non-power-of-two depth.
module tb_fifo_v3_ft;

  logic       clk = 1'b0;
  logic       tm  = 1'b0;
  logic       rst   [3];
  logic       flush [3];
  logic       push  [3];
  logic       pop   [3];
  logic [7:0] din   [3];
  logic [7:0] dout  [3];
  logic [2:0] usage [3];
  logic       full  [3];
  logic       empty [3];

  logic [7:0] sb [$];
  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fifo_v3_ft #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]), .testmode_i(tm),
    .full_o(full[0]), .empty_o(empty[0]), .usage_o(usage[0]),
    .data_i(din[0]), .push_i(push[0]), .data_o(dout[0]), .pop_i(pop[0])
  );

  fifo_v3_ft #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]), .testmode_i(tm),
    .full_o(full[1]), .empty_o(empty[1]), .usage_o(usage[1]),
    .data_i(din[1]), .push_i(push[1]), .data_o(dout[1]), .pop_i(pop[1])
  );

  fifo_v3_ft #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_c (
    .clk_i(clk), .rst_i(rst[2]), .flush_i(flush[2]), .testmode_i(tm),
    .full_o(full[2]), .empty_o(empty[2]), .usage_o(usage[2]),
    .data_i(din[2]), .push_i(push[2]), .data_o(dout[2]), .pop_i(pop[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance d; outputs are checked against the queue model
  // before the edge, then the model is advanced as the FIFO should be.
  task automatic step(input int d, input int depth, input bit ft, input bit ps,
                      input logic [7:0] w, input bit pp, input bit fl, input bit rs,
                      input string tag);
    int sz;
    bit byp;
    @(negedge clk);
    push[d]  = ps;
    din[d]   = w;
    pop[d]   = pp;
    flush[d] = fl;
    rst[d]   = rs;
    #1;
    sz  = sb.size();
    byp = ft && (sz == 0) && ps;
    chk({tag, "/usage"}, 32'(usage[d]), 32'(sz));
    chk({tag, "/full"},  32'(full[d]),  32'(sz == depth));
    chk({tag, "/empty"}, 32'(empty[d]), 32'((sz == 0) && !byp));
    if (sz > 0) begin
      chk({tag, "/data"}, 32'(dout[d]), 32'(sb[0]));
    end else if (byp) begin
      chk({tag, "/bypass_data"}, 32'(dout[d]), 32'(w));
    end
    $display("%s: dut%0d push=%0b din=%02h pop=%0b flush=%0b rst=%0b usage=%0d empty=%0b full=%0b data_o=%02h",
             tag, d, ps, w, pp, fl, rs, usage[d], empty[d], full[d], dout[d]);
    @(posedge clk);
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (pp && sz > 0) void'(sb.pop_front());
      if (ps && sz < depth && !(byp && pp)) sb.push_back(w);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; flush[i] = 1'b0; push[i] = 1'b0; pop[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Reset state on every instance
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "reset_a");
    step(1, 4, 1, 0, 8'h00, 0, 0, 0, "reset_b");
    step(2, 3, 0, 0, 8'h00, 0, 0, 0, "reset_c");

    // Basic ordering
    step(0, 4, 0, 1, 8'h11, 0, 0, 0, "push11");
    step(0, 4, 0, 1, 8'h22, 0, 0, 0, "push22");
    step(0, 4, 0, 1, 8'h33, 0, 0, 0, "push33");
    step(0, 4, 0, 0, 8'h00, 1, 0, 0, "pop1");
    step(0, 4, 0, 0, 8'h00, 1, 0, 0, "pop2");
    step(0, 4, 0, 0, 8'h00, 1, 0, 0, "pop3");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "drained");

    // Fill, push-on-full with pop, drain
    for (int i = 0; i < 4; i++) step(0, 4, 0, 1, 8'(8'hA0 + i), 0, 0, 0, "fill");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "full");
    step(0, 4, 0, 1, 8'hFF, 1, 0, 0, "push_full_pop");
    for (int i = 0; i < 3; i++) step(0, 4, 0, 0, 8'h00, 1, 0, 0, "drain");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "drained2");

    // Fall-through pass-through and bypass store
    step(1, 4, 1, 1, 8'h5A, 1, 0, 0, "ft_through");
    step(1, 4, 1, 0, 8'h00, 0, 0, 0, "ft_after");
    step(1, 4, 1, 1, 8'h77, 0, 0, 0, "ft_store");
    step(1, 4, 1, 0, 8'h00, 0, 0, 0, "ft_held");
    step(1, 4, 1, 0, 8'h00, 1, 0, 0, "ft_pop");
    step(1, 4, 1, 0, 8'h00, 0, 0, 0, "ft_empty");

    // Wrap-around on DEPTH=3 with streaming push/pop
    step(2, 3, 0, 1, 8'h00, 0, 0, 0, "wrap_first");
    for (int i = 1; i < 10; i++) step(2, 3, 0, 1, 8'(i), 1, 0, 0, "wrap_stream");
    step(2, 3, 0, 0, 8'h00, 1, 0, 0, "wrap_last");
    step(2, 3, 0, 0, 8'h00, 0, 0, 0, "wrap_empty");

    // Flush wins over a concurrent push
    step(0, 4, 0, 1, 8'hC1, 0, 0, 0, "pre_flush");
    step(0, 4, 0, 1, 8'hC2, 0, 0, 0, "pre_flush");
    step(0, 4, 0, 1, 8'hC3, 0, 1, 0, "flush_push");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "post_flush");
    step(0, 4, 0, 1, 8'hD4, 0, 0, 0, "push_after_flush");
    step(0, 4, 0, 0, 8'h00, 1, 0, 0, "pop_after_flush");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "empty_after_flush");

    // Reset mid-stream
    step(0, 4, 0, 1, 8'hE1, 0, 0, 0, "pre_rst");
    step(0, 4, 0, 1, 8'hE2, 0, 0, 0, "pre_rst");
    step(0, 4, 0, 1, 8'hE3, 0, 0, 0, "pre_rst");
    step(0, 4, 0, 0, 8'h00, 0, 0, 1, "mid_rst");
    step(0, 4, 0, 0, 8'h00, 0, 0, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
